// File: rtl/control_pkg.sv
// Shared encodings for the multicycle ARM control path: FSM states, ALU
// operations, data-processing commands and condition codes.
package control_pkg;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_ADC = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/alu_decoder.sv
// Data-processing command decode: ALU operation, flag-write mask, suppressed
// register write and shifter routing.
module alu_decoder
  import control_pkg::*;
(
  input  logic [3:0] cmd,
  input  logic       s_bit,
  output logic [2:0] alu_ctl,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       shift
);

  always_comb begin
    alu_ctl  = ALU_ADD;
    flag_w   = 2'b00;
    no_write = 1'b0;
    shift    = 1'b0;
    case (cmd)
      CMD_AND: begin alu_ctl = ALU_AND; flag_w = s_bit ? 2'b10 : 2'b00; end
      CMD_SUB: begin alu_ctl = ALU_SUB; flag_w = s_bit ? 2'b11 : 2'b00; end
      CMD_ADD: begin alu_ctl = ALU_ADD; flag_w = s_bit ? 2'b11 : 2'b00; end
      CMD_ADC: begin alu_ctl = ALU_ADC; flag_w = s_bit ? 2'b11 : 2'b00; end
      CMD_ORR: begin alu_ctl = ALU_ORR; flag_w = s_bit ? 2'b10 : 2'b00; end
      // compare always updates all four flags and never writes a register
      CMD_CMP: begin alu_ctl = ALU_SUB; flag_w = 2'b11; no_write = 1'b1; end
      CMD_MOV: begin
        alu_ctl = ALU_ADD;
        shift   = 1'b1;
        flag_w  = s_bit ? 2'b10 : 2'b00;
      end
      default: no_write = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM sequencer: per-state datapath strobes and selects, NZCV flag
// register and condition-field evaluation in DECODE.
module multicycle_control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_w,
  output logic       adr_src,
  output logic       mem_w,
  output logic       ir_w,
  output logic       reg_w,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [2:0] alu_ctl,
  output logic       shift,
  output logic [3:0] flags
);

  logic [3:0] state, state_nx;
  logic [2:0] dec_alu_ctl;
  logic [1:0] flag_w;
  logic       no_write, dec_shift, cond_ok;
  logic       f_n, f_z, f_c, f_v;

  assign {f_n, f_z, f_c, f_v} = flags;

  alu_decoder u_alu_decoder (
    .cmd      (funct[4:1]),
    .s_bit    (funct[0]),
    .alu_ctl  (dec_alu_ctl),
    .flag_w   (flag_w),
    .no_write (no_write),
    .shift    (dec_shift)
  );

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = f_z;
      COND_NE: cond_ok = !f_z;
      COND_CS: cond_ok = f_c;
      COND_CC: cond_ok = !f_c;
      COND_MI: cond_ok = f_n;
      COND_PL: cond_ok = !f_n;
      COND_VS: cond_ok = f_v;
      COND_VC: cond_ok = !f_v;
      COND_HI: cond_ok = f_c && !f_z;
      COND_LS: cond_ok = !f_c || f_z;
      COND_GE: cond_ok = (f_n == f_v);
      COND_LT: cond_ok = (f_n != f_v);
      COND_GT: cond_ok = !f_z && (f_n == f_v);
      COND_LE: cond_ok = f_z || (f_n != f_v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= FETCH;
      flags <= 4'b0000;
    end else begin
      state <= state_nx;
      if (state == EXECR || state == EXECI) begin
        if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
        if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
      end
    end
  end

  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:  state_nx = DECODE;
      DECODE: begin
        if (cond_ok) begin
          case (op)
            2'b00:   state_nx = funct[5] ? EXECI : EXECR;
            2'b01:   state_nx = MEMADR;
            2'b10:   state_nx = BRANCH;
            default: state_nx = FETCH;
          endcase
        end
      end
      MEMADR: state_nx = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_nx = MEMWB;
      EXECR,
      EXECI:  state_nx = no_write ? FETCH : ALUWB;
      default: state_nx = FETCH;
    endcase
  end

  always_comb begin
    pc_w       = 1'b0;
    adr_src    = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = ALU_ADD;
    shift      = 1'b0;
    imm_src    = op;
    reg_src    = {op == 2'b01, op == 2'b10};
    case (state)
      FETCH: begin
        ir_w       = 1'b1;
        pc_w       = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: alu_src_b = 2'b01;
      MEMRD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        pc_w       = (rd == 4'd15);
        reg_w      = (rd != 4'd15);
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECR: begin
        alu_ctl = dec_alu_ctl;
        shift   = dec_shift;
      end
      EXECI: begin
        alu_src_b = 2'b01;
        alu_ctl   = dec_alu_ctl;
        shift     = dec_shift;
      end
      ALUWB: begin
        pc_w  = (rd == 4'd15);
        reg_w = (rd != 4'd15);
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_w       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is turned into an expected
// per-cycle output trace and flag result, then compared cycle by cycle.
module tb_multicycle_control;

  logic       clk, n_reset;
  logic [3:0] cond, rd, alu_flags, flags;
  logic [1:0] op, result_src, alu_src_b, imm_src, reg_src;
  logic [5:0] funct;
  logic       pc_w, adr_src, mem_w, ir_w, reg_w, alu_src_a, shift;
  logic [2:0] alu_ctl;

  int checks = 0;
  int failures = 0;
  logic [3:0] flags_m = 4'b0000;

  multicycle_control dut (
    .clk(clk), .n_reset(n_reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_w(pc_w), .adr_src(adr_src), .mem_w(mem_w),
    .ir_w(ir_w), .reg_w(reg_w), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_src(reg_src),
    .alu_ctl(alu_ctl), .shift(shift), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed as {pc_w, adr_src, mem_w, ir_w, reg_w, result_src, alu_src_a, alu_src_b, alu_ctl, shift}
  function automatic logic [13:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [2:0] ac, input logic sh);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, sh};
  endfunction

  function automatic logic [17:0] observed();
    return {pc_w, adr_src, mem_w, ir_w, reg_w, result_src, alu_src_a, alu_src_b,
            alu_ctl, shift, imm_src, reg_src};
  endfunction

  // Even codes test a predicate, odd codes its inverse; 1110 is "always" so 1111 is "never".
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af, input string tag);
    logic [13:0] q[$];
    int exec_idx;
    logic [3:0] nf, cmd;
    logic ok, wb15, is_arith, is_logic, is_cmp, nw, sh;
    logic [2:0] ctl;
    logic [1:0] fw;
    logic [17:0] exp_v, act;
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
    exec_idx = -1;
    nf = flags_m;
    wb15 = (r == 4'd15);
    q.push_back(mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'b000, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0));
    ok = cond_pass(c, flags_m);
    if (ok && o == 2'b00) begin
      cmd = f[4:1];
      is_arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0101);
      is_logic = (cmd == 4'b0000) || (cmd == 4'b1100) || (cmd == 4'b1101);
      is_cmp = (cmd == 4'b1010);
      sh = (cmd == 4'b1101);
      nw = !(is_arith || is_logic);
      case (cmd)
        4'b0000: ctl = 3'b010;
        4'b0010, 4'b1010: ctl = 3'b001;
        4'b0101: ctl = 3'b100;
        4'b1100: ctl = 3'b011;
        default: ctl = 3'b000;
      endcase
      fw = is_cmp ? 2'b11 : (!f[0] ? 2'b00 : (is_arith ? 2'b11 : (is_logic ? 2'b10 : 2'b00)));
      if (fw[1]) nf[3:2] = af[3:2];
      if (fw[0]) nf[1:0] = af[1:0];
      exec_idx = 2;
      q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, {1'b0, f[5]}, ctl, sh));
      if (!nw) q.push_back(mk(wb15, 0, 0, 0, !wb15, 2'b00, 0, 2'b00, 3'b000, 0));
    end else if (ok && o == 2'b01) begin
      q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0));
      if (f[0]) begin
        q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0));
        q.push_back(mk(wb15, 0, 0, 0, !wb15, 2'b01, 0, 2'b00, 3'b000, 0));
      end else begin
        q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0));
      end
    end else if (ok && o == 2'b10) begin
      q.push_back(mk(1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 3'b000, 0));
    end
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      exp_v = {q[i], o, {o == 2'b01, o == 2'b10}};
      act = observed();
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL %s cycle%0d outputs: got %h expected %h", tag, i, act, exp_v);
      end
      checks++;
      if (flags !== flags_m) begin
        failures++;
        $display("FAIL %s cycle%0d flags: got %b expected %b", tag, i, flags, flags_m);
      end
      if (i == exec_idx) flags_m = nf;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    cond = 4'b1110; op = 2'b00; funct = 6'b0; rd = 4'd0; alu_flags = 4'b0;
    #1;
    checks++;
    if (observed() !== {mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'b000, 0), 4'b0000}) begin
      failures++;
      $display("FAIL reset outputs: got %h", observed());
    end
    checks++;
    if (flags !== 4'b0000) begin
      failures++;
      $display("FAIL reset flags: got %b expected 0000", flags);
    end
    @(posedge clk);
    #2;
    n_reset = 1'b1;
    flags_m = 4'b0000;
  endtask

  task automatic test_directed();
    run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b1111, "add_r1");
    run_instr(4'b1110, 2'b01, 6'b000001, 4'd2, 4'b0000, "ldr");
    run_instr(4'b1110, 2'b01, 6'b000000, 4'd2, 4'b0000, "str");
    run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0100, "cmp");
    checks++;
    if (flags !== 4'b0100) begin
      failures++;
      $display("FAIL cmp_flags: got %b expected 0100", flags);
    end
    run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000, "beq");
    run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000, "bne_skip");
    run_instr(4'b1110, 2'b00, 6'b001001, 4'd3, 4'b1011, "adds");
    checks++;
    if (flags !== 4'b1011) begin
      failures++;
      $display("FAIL adds_flags: got %b expected 1011", flags);
    end
    run_instr(4'b1110, 2'b00, 6'b000001, 4'd3, 4'b0100, "ands");
    checks++;
    if (flags !== 4'b0111) begin
      failures++;
      $display("FAIL ands_flags: got %b expected 0111", flags);
    end
    run_instr(4'b1110, 2'b00, 6'b011010, 4'd15, 4'b0000, "mov_pc");
    run_instr(4'b1111, 2'b00, 6'b001000, 4'd1, 4'b0000, "never");
    run_instr(4'b1110, 2'b11, 6'b001000, 4'd1, 4'b0000, "op11");
  endtask

  task automatic test_abort();
    cond = 4'b1110; op = 2'b01; funct = 6'b000001; rd = 4'd2; alu_flags = 4'b0;
    repeat (3) @(posedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (observed() !== {mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'b000, 0), 4'b0110}) begin
      failures++;
      $display("FAIL abort_async outputs: got %h", observed());
    end
    checks++;
    if (mem_w !== 1'b0 || flags !== 4'b0000) begin
      failures++;
      $display("FAIL abort_async mem_w/flags: got %b/%b expected 0/0000", mem_w, flags);
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== {mk(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 3'b000, 0), 4'b0110}) begin
      failures++;
      $display("FAIL abort_hold outputs: got %h", observed());
    end
    #1;
    n_reset = 1'b1;
    flags_m = 4'b0000;
    run_instr(4'b1110, 2'b00, 6'b001000, 4'd4, 4'b0000, "after_abort");
  endtask

  task automatic test_random();
    logic [3:0] cmds[7];
    logic [3:0] c, r;
    logic [1:0] o;
    logic [5:0] f;
    cmds = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1100, 4'b1101};
    for (int n = 0; n < 200; n++) begin
      c = ($urandom_range(0, 9) < 6) ? 4'b1110 : 4'($urandom_range(0, 15));
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 6)];
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      run_instr(c, o, f, r, 4'($urandom_range(0, 15)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
